// File: rtl/midi_parser_pkg.sv
// midi_parser_pkg: shared constants, types and helpers for the MIDI byte parser.
//   - status nibbles 8..E, system byte constants F0/F7/F8/FF
//   - event type codes 0..6 and the parser state encoding
//   - midi_event_t: one complete channel-voice event as presented to the consumer
package midi_parser_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWaitD1,
        StWaitD2,
        StSysex
    } state_e;

    localparam logic [3:0] NibNoteOff   = 4'h8;
    localparam logic [3:0] NibNoteOn    = 4'h9;
    localparam logic [3:0] NibPolyAt    = 4'hA;
    localparam logic [3:0] NibCc        = 4'hB;
    localparam logic [3:0] NibProgram   = 4'hC;
    localparam logic [3:0] NibChanAt    = 4'hD;
    localparam logic [3:0] NibPitchBend = 4'hE;
    localparam logic [3:0] NibSystem    = 4'hF;

    localparam logic [7:0] ByteSysexStart = 8'hF0;
    localparam logic [7:0] ByteSysexEnd   = 8'hF7;
    localparam logic [7:0] ByteRtFirst    = 8'hF8;
    localparam logic [7:0] ByteSysReset   = 8'hFF;

    typedef enum logic [2:0] {
        EvNoteOff   = 3'd0,
        EvNoteOn    = 3'd1,
        EvPolyAt    = 3'd2,
        EvCc        = 3'd3,
        EvProgram   = 3'd4,
        EvChanAt    = 3'd5,
        EvPitchBend = 3'd6
    } ev_type_e;

    typedef struct packed {
        logic [2:0] ev_type;
        logic [3:0] ch;
        logic [6:0] d1;
        logic [6:0] d2;
    } midi_event_t;

    // Program change and channel aftertouch carry one data byte, the rest two.
    function automatic logic two_data(input logic [3:0] nib);
        return !(nib == NibProgram || nib == NibChanAt);
    endfunction

    // Note-on with velocity 0 is reported as note-off.
    function automatic ev_type_e ev_type_of(input logic [3:0] nib, input logic [6:0] d2);
        case (nib)
            NibNoteOff:   return EvNoteOff;
            NibNoteOn:    return (d2 == 7'd0) ? EvNoteOff : EvNoteOn;
            NibPolyAt:    return EvPolyAt;
            NibCc:        return EvCc;
            NibProgram:   return EvProgram;
            NibChanAt:    return EvChanAt;
            NibPitchBend: return EvPitchBend;
            default:      return EvNoteOff;
        endcase
    endfunction

endpackage

// File: rtl/midi_parser_if.sv
// midi_parser_if: event valid/ready channel from the parser to the voice/control logic.
//   ev_valid, ev_type[2:0], ev_ch[3:0], ev_d1[6:0], ev_d2[6:0] : producer -> consumer
//   ev_ready                                                  : consumer -> producer
interface midi_parser_if;
    logic       ev_valid;
    logic       ev_ready;
    logic [2:0] ev_type;
    logic [3:0] ev_ch;
    logic [6:0] ev_d1;
    logic [6:0] ev_d2;

    modport master (output ev_valid, ev_type, ev_ch, ev_d1, ev_d2, input ev_ready);
    modport slave  (input ev_valid, ev_type, ev_ch, ev_d1, ev_d2, output ev_ready);
endinterface

// File: rtl/midi_parser_event_reg.sv
// midi_parser_event_reg: output holding register for parsed events.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   ce_i          : clock enable qualifying every update
//   load_i, ev_i  : a filtered completion and its contents
//   ev_if         : valid/ready event channel (master side)
//   ovf_o         : sticky, set when a completion arrives while an event is stuck
module midi_parser_event_reg
    import midi_parser_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          ce_i,
    input  logic          load_i,
    input  midi_event_t   ev_i,
    midi_parser_if.master ev_if,
    output logic          ovf_o
);

    logic        valid_q, valid_d;
    logic        ovf_q, ovf_d;
    midi_event_t ev_q, ev_d;

    always_comb begin
        valid_d = valid_q;
        ovf_d   = ovf_q;
        ev_d    = ev_q;
        if (ce_i) begin
            if (valid_q && !ev_if.ev_ready) begin
                // Pending event is kept; a new one is lost.
                if (load_i) begin
                    ovf_d = 1'b1;
                end
            end else if (load_i) begin
                valid_d = 1'b1;
                ev_d    = ev_i;
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            ev_q    <= '0;
        end else begin
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            ev_q    <= ev_d;
        end
    end

    assign ev_if.ev_valid = valid_q;
    assign ev_if.ev_type  = ev_q.ev_type;
    assign ev_if.ev_ch    = ev_q.ch;
    assign ev_if.ev_d1    = ev_q.d1;
    assign ev_if.ev_d2    = ev_q.d2;
    assign ovf_o          = ovf_q;

endmodule

// File: rtl/midi_parser.sv
// midi_parser: MIDI byte-stream parser with running status, SysEx/real-time discard
// and channel filter, presenting channel-voice messages as single events.
//   clk_i, rst_ni     : clock, asynchronous active-low reset
//   ce_i              : clock enable qualifying every update
//   dv_i, di_i[7:0]   : byte strobe and byte from the UART receiver
//   ch_ld_i, ch_in_i  : load a new filter channel
//   omni_i            : accept every channel
//   ev_if             : valid/ready event channel (master side)
//   ovf_o             : sticky event-dropped flag
module midi_parser
    import midi_parser_pkg::*;
#(
    parameter logic [3:0] DefCh = 4'd0
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          ce_i,
    input  logic          dv_i,
    input  logic [7:0]    di_i,
    input  logic          ch_ld_i,
    input  logic [3:0]    ch_in_i,
    input  logic          omni_i,
    midi_parser_if.master ev_if,
    output logic          ovf_o
);

    state_e      state_q, state_d;
    logic [7:0]  rs_q, rs_d;
    logic        rsv_q, rsv_d;
    logic [6:0]  d1_q, d1_d;
    logic [3:0]  ch_q, ch_d;
    logic        cpl;
    logic [6:0]  cpl_d1, cpl_d2;
    logic        load;
    midi_event_t ev_new;

    always_comb begin
        state_d = state_q;
        rs_d    = rs_q;
        rsv_d   = rsv_q;
        d1_d    = d1_q;
        ch_d    = ch_q;
        cpl     = 1'b0;
        cpl_d1  = di_i[6:0];
        cpl_d2  = 7'd0;
        if (ce_i && ch_ld_i) begin
            ch_d = ch_in_i;
        end
        if (ce_i && dv_i) begin
            if (!di_i[7]) begin
                if (rsv_q) begin
                    case (state_q)
                        StWaitD1: begin
                            d1_d = di_i[6:0];
                            if (two_data(rs_q[7:4])) begin
                                state_d = StWaitD2;
                            end else begin
                                cpl = 1'b1;
                            end
                        end
                        StWaitD2: begin
                            cpl     = 1'b1;
                            cpl_d1  = d1_q;
                            cpl_d2  = di_i[6:0];
                            state_d = StWaitD1;
                        end
                        default: ;
                    endcase
                end
            end else if (di_i[7:4] != NibSystem) begin
                // Channel status restarts the message and becomes running status.
                rs_d    = di_i;
                rsv_d   = 1'b1;
                state_d = StWaitD1;
            end else if (di_i == ByteSysexStart) begin
                rsv_d   = 1'b0;
                state_d = StSysex;
            end else if (di_i >= ByteRtFirst && di_i != ByteSysReset) begin
                // Real-time bytes pass through the message untouched.
            end else begin
                // F1..F7 (F7 also ends SysEx) and FF.
                rsv_d   = 1'b0;
                state_d = StIdle;
            end
        end
    end

    // Filter uses the channel register as it stood before any load this cycle.
    assign load   = cpl && (omni_i || rs_q[3:0] == ch_q);
    assign ev_new = '{ev_type: ev_type_of(rs_q[7:4], cpl_d2), ch: rs_q[3:0],
                      d1: cpl_d1, d2: cpl_d2};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            rs_q    <= 8'h00;
            rsv_q   <= 1'b0;
            d1_q    <= 7'd0;
            ch_q    <= DefCh;
        end else begin
            state_q <= state_d;
            rs_q    <= rs_d;
            rsv_q   <= rsv_d;
            d1_q    <= d1_d;
            ch_q    <= ch_d;
        end
    end

    midi_parser_event_reg u_event_reg (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .ce_i   (ce_i),
        .load_i (load),
        .ev_i   (ev_new),
        .ev_if  (ev_if),
        .ovf_o  (ovf_o)
    );

endmodule
